// File: rtl/down_counter_4bit.sv
// Programmable down-counter/timer: load a start value, decrement while running,
// pulse done for one cycle on expiry, optionally reload and keep going.
//
// Control handshake: there is no valid/ready pair here. load, start, pause and
// auto_reload are level inputs that the counter samples on every rising clk edge.
// load takes priority over everything except reset, and start/pause only matter
// in the states listed in the state logic below.
module down_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    EXPIRE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;

  // State, count and reload registers; reset clears them without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
    end
  end

  // Next-state and next-count logic; load overrides whatever state we are in.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      state_next  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // A zero count has nothing to time, so start is ignored.
          if (start && (count != '0)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = HOLD;
          end else if (count > WIDTH'(1)) begin
            count_next = count - WIDTH'(1);
          end else begin
            // Last decrement: land on zero, never wrap.
            count_next = '0;
            state_next = EXPIRE;
          end
        end
        HOLD: begin
          if (!pause) begin
            state_next = RUN;
          end
        end
        EXPIRE: begin
          if (auto_reload && (reload != '0)) begin
            count_next = reload;
            state_next = RUN;
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the registered state.
  assign busy      = (state != IDLE);
  assign done      = (state == EXPIRE);
  assign dbg_state = state;

endmodule

// File: doc/down_counter_4bit.md
Name: down_counter_4bit

Overview:
- Programmable 4-bit down-counter/timer, the counterpart to the team's free-running 4-bit up-counter.
- Loads a start value, decrements once per clock while running, and flags expiry with a one-cycle done pulse.
- Supports pause and optional auto-reload, so it serves as a periodic tick or timeout source for lab designs.

Parameters:
WIDTH, 4, width of count, load_value and the internal reload register

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
load  input  1  load load_value into count and reload register
load_value  input  WIDTH  value captured on load
start  input  1  begin counting from current count
pause  input  1  freeze count while high (RUN/HOLD only)
auto_reload  input  1  on expiry, restart from reload register
count  output  WIDTH  current counter value
busy  output  1  high when state != IDLE
done  output  1  one-cycle expiry pulse

Behaviour:
- One clock (clk). Reset is asynchronous and active-low: reset=0 immediately forces count=0, reload register=0, state=IDLE, busy=0, done=0, with no clock edge needed. Normal operation resumes on the first rising edge after reset returns to 1.
- All outputs are registered (Moore). busy and done are decoded from registered state.
- States: IDLE, RUN, HOLD, EXPIRE.
- Priority per edge: reset > load > state logic.
- load=1 in any state:
  - count <= load_value, reload <= load_value, next state IDLE.
  - Aborts a run, pause or expiry. done is 0 on the next cycle.
- IDLE:
  - start=1 and count!=0 -> RUN. count is unchanged on this edge.
  - start=1 and count==0 -> ignored; stay IDLE, no done.
  - pause is ignored.
- RUN:
  - pause=1 -> HOLD; count is not decremented on that edge.
  - Otherwise, if count>1: count <= count-1.
  - Otherwise, if count==1: count <= 0 and go to EXPIRE.
  - start is ignored.
- HOLD:
  - count is frozen.
  - pause=0 -> RUN, with the first decrement on the following edge.
  - start is ignored.
- EXPIRE:
  - Lasts exactly one cycle, with done=1 and count=0.
  - Next: if auto_reload=1 and reload!=0, count <= reload and go to RUN.
  - Otherwise go to IDLE with count held at 0.
  - pause during EXPIRE does not extend it; pause is evaluated in RUN.
- Timing:
  - From the start edge, count reaches 0 after N decrement edges, where N = loaded value.
  - With auto_reload, the period is N+1 cycles (N values plus one EXPIRE cycle at 0).
- Arithmetic: count never decrements below 0 and never wraps 0 -> max. Load of 0 followed by start does nothing.
- auto_reload is sampled only in EXPIRE. Changing it mid-run only affects the next expiry.
- load and start asserted on the same edge: load wins, start is dropped, and the counter waits in IDLE.

Test Plan:
1. Load 5, then pulse start -> count 5,4,3,2,1,0 on consecutive edges. done=1 for exactly the cycle count=0, busy=1 from RUN through EXPIRE, then busy=0 and count stays 0.
2. auto_reload=1, load 3, start -> count 3,2,1,0,3,2,1,0,... done pulses every 4 cycles. Drop auto_reload -> after the next 0, go to IDLE.
3. Load 9, start, assert pause when count=6 for 3 cycles -> count holds 6 for 3 cycles (busy=1, done=0). After release, count goes 5 on the second edge.
4. Drive reset=0 mid-run at count=7, between clock edges -> count=0, busy=0, done=0 immediately. Release reset -> IDLE, and start with count 0 has no effect.
5. Load 4'hF, start, auto_reload=0 -> 15 down to 0 in 15 edges, one done pulse, and no wrap to 4'hF.
6. Load 9, start; at count=7 assert load with value 2 and start together -> count=2, busy=0 next cycle. A later start counts 2,1,0 with done.
